regfile_wb_ctrl: RTL and testbench
==================================

REGFILE_WB_CTRL -- requirements
Module: regfile_wb_ctrl

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive cycles the ALU requester may wait before it wins; legal range 1..15.
REQ-002 SHALL have parameter XLEN, default 32, meaning register data width.
REQ-003 SHALL have one clock and an asynchronous active-low reset:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU writeback request
- alu_ready  out  1  ALU request granted this cycle
- alu_rd  in  5  ALU destination register
- alu_data  in  XLEN  ALU write data
- mem_valid  in  1  load writeback request
- mem_ready  out  1  load request granted this cycle
- mem_rd  in  5  load destination register
- mem_data  in  XLEN  load write data
- rsv_valid  in  1  issue stage reserves a register for an outstanding load
- rsv_rd  in  5  register being reserved
- chk_s1sel  in  5  source 1 of the instruction being issued
- chk_s2sel  in  5  source 2 of the instruction being issued
- hazard  out  1  a checked source is pending
- sb_err  out  1  sticky scoreboard protocol error
- rf_wen  out  1  register file write enable
- rf_dsel  out  5  register file destination select
- rf_d  out  XLEN  register file write data

Function
REQ-004 SHALL complete a handshake on a port when valid and ready are both high at a rising edge.
REQ-005 SHALL assert at most one of alu_ready and mem_ready in any cycle; a ready SHALL be high only while its own valid is high.
REQ-006 SHALL grant mem by default when both ports are valid, and SHALL grant alu instead when starve_cnt equals STARVE_LIMIT.
REQ-007 SHALL keep a starve counter, starve_cnt:
- increments when alu_valid is high and alu_ready is low
- clears on any ALU handshake
- saturates at STARVE_LIMIT
REQ-008 SHALL register the granted request into the rf_* outputs at the handshake edge, so rf_wen is high in the following cycle (latency 1), for exactly one cycle per handshake.
REQ-009 SHALL accept a handshake with rd=0 while leaving rf_wen low for that slot.
REQ-010 SHALL keep one pending bit per register 1..31; rsv_valid with a nonzero rsv_rd SHALL set the bit for rsv_rd at the edge, and rsv_rd=0 SHALL be ignored.
REQ-011 SHALL clear the pending bit for rf_dsel in any cycle where rf_wen is high and the write came from the mem port.
REQ-012 SHALL give the set priority when a set and a clear hit the same register in the same cycle; the bit stays set.
REQ-013 SHALL drive hazard combinationally high when either chk_s1sel or chk_s2sel is nonzero and its pending bit is set.
REQ-014 SHALL set sb_err and hold it until reset when any of the following occurs:
- rsv_valid targets a register whose bit is already pending
- a mem handshake targets a nonzero register that is not pending

Reset
REQ-015 SHALL, while rst_n is low, asynchronously force:
- rf_wen=0, rf_dsel=0, rf_d=0
- all pending bits=0, starve_cnt=0, sb_err=0
REQ-016 SHALL discard any handshake in flight when reset asserts mid-operation, so no write is issued after reset releases.
REQ-017 SHALL hold the ready outputs low while rst_n is low.

Configuration
REQ-018 SHALL, when REGFILE_WB_CTRL_BYPASS_EN is defined, treat a source as not hazardous when it matches rf_dsel with rf_wen high and the pending clear is occurring this cycle, and SHALL add these outputs:
- fwd1_hit, fwd2_hit (1 bit each)
- fwd_data (XLEN), equal to rf_d
REQ-019 SHALL, when REGFILE_WB_CTRL_BYPASS_EN is undefined, omit the fwd ports and follow REQ-013 unchanged.

Structure
REQ-020 SHALL take XLEN default, REG_AW=5, NUM_REGS=32 and the starve counter width constant from shared package regfile_pkg.
REQ-021 SHALL implement the pending bits, the set/clear logic and sb_err in one sub-module, regfile_scoreboard; arbitration and the output stage SHALL stay in the top module.

Verification
REQ-022 SHALL cover: mem_valid and alu_valid both held high continuously with STARVE_LIMIT=4 -> four mem grants, then one alu grant, repeating; never both readys high.
REQ-023 SHALL cover: an ALU handshake with rd=7 and data 0xDEADBEEF at edge N -> rf_wen=1, rf_dsel=7, rf_d=0xDEADBEEF during cycle N+1 only.
REQ-024 SHALL cover: reserve x5, then chk_s1sel=5 -> hazard=1; a mem write to x5 drops hazard the cycle after rf_wen (immediately when BYPASS_EN is defined, with fwd1_hit=1).
REQ-025 SHALL cover: reserve x6 twice, then a mem write to x9 that is not pending -> sb_err=1 and it stays 1 until rst_n low.
REQ-026 SHALL cover: an ALU handshake to x0 -> alu_ready=1 and rf_wen stays 0; rst_n pulsed low during a pending output slot -> rf_wen=0 and all pending bits clear.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback controller.
// Optional forwarding build: REGFILE_WB_CTRL_BYPASS_EN.
package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;
  localparam int SCW      = 4;

  typedef logic [REG_AW-1:0] reg_idx_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_e;

  function automatic logic [NUM_REGS-1:0] onehot(
    input reg_idx_t r
  );
    return NUM_REGS'(1) << r;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-load scoreboard: per-register pending bits, hazard lookup, sticky error.
// With REGFILE_WB_CTRL_BYPASS_EN a completing load write masks its own hazard.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rsv_valid,
  input  reg_idx_t        rsv_rd,
  input  logic            mem_hs,
  input  reg_idx_t        mem_rd,
  input  logic            rf_wen,
  input  reg_idx_t        rf_dsel,
  input  wb_src_e         wr_src,
  input  reg_idx_t        chk_s1sel,
  input  reg_idx_t        chk_s2sel,
`ifdef REGFILE_WB_CTRL_BYPASS_EN
  input  logic [XLEN-1:0] rf_d,
  output logic            fwd1_hit,
  output logic            fwd2_hit,
  output logic [XLEN-1:0] fwd_data,
`endif
  output logic            hazard,
  output logic            sb_err
);

  logic [NUM_REGS-1:0] pend_q;
  logic [NUM_REGS-1:0] pend_d;
  logic [NUM_REGS-1:0] set_m;
  logic [NUM_REGS-1:0] clr_m;
  logic                rsv_set;
  logic                clr_en;
  logic                err_d;
  logic                p1;
  logic                p2;

  always_comb begin
    rsv_set = rsv_valid && (rsv_rd != '0);
    clr_en  = rf_wen && (wr_src == SRC_MEM);
    set_m   = rsv_set ? onehot(rsv_rd) : '0;
    clr_m   = clr_en ? onehot(rf_dsel) : '0;
    // set wins over a same-cycle clear; x0 never pends
    pend_d  = ((pend_q & ~clr_m) | set_m)
            & ~onehot(reg_idx_t'(0));
    err_d   = (rsv_set && pend_q[rsv_rd])
           || (mem_hs && (mem_rd != '0)
               && !pend_q[mem_rd]);
    p1      = (chk_s1sel != '0) && pend_q[chk_s1sel];
    p2      = (chk_s2sel != '0) && pend_q[chk_s2sel];
  end

`ifdef REGFILE_WB_CTRL_BYPASS_EN
  always_comb begin
    fwd1_hit = clr_en && (chk_s1sel != '0)
            && (chk_s1sel == rf_dsel);
    fwd2_hit = clr_en && (chk_s2sel != '0)
            && (chk_s2sel == rf_dsel);
    fwd_data = rf_d;
    hazard   = (p1 && !fwd1_hit) || (p2 && !fwd2_hit);
  end
`else
  always_comb begin
    hazard = p1 || p2;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      sb_err <= 1'b0;
    end else begin
      pend_q <= pend_d;
      if (err_d) sb_err <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Writeback arbiter between ALU and load ports with anti-starvation and output stage.
// Optional forwarding ports under REGFILE_WB_CTRL_BYPASS_EN.
module regfile_wb_ctrl
  import regfile_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int XLEN         = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  reg_idx_t        alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  reg_idx_t        mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            rsv_valid,
  input  reg_idx_t        rsv_rd,
  input  reg_idx_t        chk_s1sel,
  input  reg_idx_t        chk_s2sel,
`ifdef REGFILE_WB_CTRL_BYPASS_EN
  output logic            fwd1_hit,
  output logic            fwd2_hit,
  output logic [XLEN-1:0] fwd_data,
`endif
  output logic            hazard,
  output logic            sb_err,
  output logic            rf_wen,
  output reg_idx_t        rf_dsel,
  output logic [XLEN-1:0] rf_d
);

  localparam logic [SCW-1:0] LIMIT = SCW'(STARVE_LIMIT);

  logic [SCW-1:0] starve_cnt;
  logic           alu_win;
  logic           alu_hs;
  logic           mem_hs;
  wb_src_e        wr_src;

  // mem has priority unless the ALU has waited LIMIT cycles
  always_comb begin
    alu_win   = alu_valid
             && (!mem_valid || (starve_cnt == LIMIT));
    alu_ready = rst_n && alu_win;
    mem_ready = rst_n && mem_valid && !alu_win;
    alu_hs    = alu_valid && alu_ready;
    mem_hs    = mem_valid && mem_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (alu_hs) begin
      starve_cnt <= '0;
    end else if (alu_valid && (starve_cnt != LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wen  <= 1'b0;
      rf_dsel <= '0;
      rf_d    <= '0;
      wr_src  <= SRC_ALU;
    end else begin
      rf_wen <= 1'b0;
      if (alu_hs) begin
        rf_wen  <= (alu_rd != '0);
        rf_dsel <= alu_rd;
        rf_d    <= alu_data;
        wr_src  <= SRC_ALU;
      end else if (mem_hs) begin
        rf_wen  <= (mem_rd != '0);
        rf_dsel <= mem_rd;
        rf_d    <= mem_data;
        wr_src  <= SRC_MEM;
      end
    end
  end

  regfile_scoreboard #(
    .XLEN (XLEN)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .rsv_valid (rsv_valid),
    .rsv_rd    (rsv_rd),
    .mem_hs    (mem_hs),
    .mem_rd    (mem_rd),
    .rf_wen    (rf_wen),
    .rf_dsel   (rf_dsel),
    .wr_src    (wr_src),
    .chk_s1sel (chk_s1sel),
    .chk_s2sel (chk_s2sel),
`ifdef REGFILE_WB_CTRL_BYPASS_EN
    .rf_d      (rf_d),
    .fwd1_hit  (fwd1_hit),
    .fwd2_hit  (fwd2_hit),
    .fwd_data  (fwd_data),
`endif
    .hazard    (hazard),
    .sb_err    (sb_err)
  );

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed testbench for regfile_wb_ctrl.
// Bypass expectations switch on REGFILE_WB_CTRL_BYPASS_EN.
module tb_regfile_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        rsv_valid;
  logic [4:0]  rsv_rd;
  logic [4:0]  chk_s1sel;
  logic [4:0]  chk_s2sel;
  logic        hazard;
  logic        sb_err;
  logic        rf_wen;
  logic [4:0]  rf_dsel;
  logic [31:0] rf_d;
`ifdef REGFILE_WB_CTRL_BYPASS_EN
  logic        fwd1_hit;
  logic        fwd2_hit;
  logic [31:0] fwd_data;
`endif

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_wb_ctrl #(
    .STARVE_LIMIT (4),
    .XLEN         (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .rsv_valid (rsv_valid),
    .rsv_rd    (rsv_rd),
    .chk_s1sel (chk_s1sel),
    .chk_s2sel (chk_s2sel),
`ifdef REGFILE_WB_CTRL_BYPASS_EN
    .fwd1_hit  (fwd1_hit),
    .fwd2_hit  (fwd2_hit),
    .fwd_data  (fwd_data),
`endif
    .hazard    (hazard),
    .sb_err    (sb_err),
    .rf_wen    (rf_wen),
    .rf_dsel   (rf_dsel),
    .rf_d      (rf_d)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0;
    rsv_valid = 0; rsv_rd = 0;
    chk_s1sel = 0; chk_s2sel = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    @(negedge clk);
    rst_n = 1;
    next_cyc();
  endtask

  initial begin
    idle_in();
    rst_n = 0;
    alu_valid = 1; mem_valid = 1;
    repeat (2) @(negedge clk);
    check("rst_alu_ready", alu_ready, 0);
    check("rst_mem_ready", mem_ready, 0);
    check("rst_rf_wen", rf_wen, 0);
    check("rst_rf_dsel", rf_dsel, 0);
    check("rst_rf_d", rf_d, 0);
    check("rst_sb_err", sb_err, 0);
    idle_in();
    rst_n = 1;
    next_cyc();

    // both valid held: 4 mem grants then 1 alu grant
    alu_valid = 1; alu_rd = 1; alu_data = 32'h11;
    mem_valid = 1; mem_rd = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("arb_alu_%0d", k), alu_ready,
            (k % 5 == 4) ? 1'b1 : 1'b0);
      check($sformatf("arb_mem_%0d", k), mem_ready,
            (k % 5 == 4) ? 1'b0 : 1'b1);
      next_cyc();
    end
    idle_in();
    @(negedge clk);
    check("arb_no_err", sb_err, 0);
    next_cyc();

    // alu write x7, latency 1, single cycle
    alu_valid = 1; alu_rd = 7; alu_data = 32'hDEADBEEF;
    @(negedge clk);
    check("a7_alu_ready", alu_ready, 1);
    check("a7_mem_ready", mem_ready, 0);
    check("a7_wen_before", rf_wen, 0);
    next_cyc();
    idle_in();
    @(negedge clk);
    check("a7_wen", rf_wen, 1);
    check("a7_dsel", rf_dsel, 7);
    check("a7_d", rf_d, 32'hDEADBEEF);
    next_cyc();
    @(negedge clk);
    check("a7_wen_after", rf_wen, 0);
    next_cyc();

    // reserve x5 and x3, hazard lookups
    rsv_valid = 1; rsv_rd = 5;
    @(negedge clk);
    chk_s1sel = 5;
    #1;
    check("h5_before_rsv", hazard, 0);
    next_cyc();
    rsv_rd = 3;
    @(negedge clk);
    check("h5_set", hazard, 1);
    next_cyc();
    rsv_valid = 0; chk_s1sel = 0; chk_s2sel = 3;
    @(negedge clk);
    check("h3_s2", hazard, 1);
    next_cyc();
    chk_s2sel = 0; chk_s1sel = 5;
    mem_valid = 1; mem_rd = 5; mem_data = 32'h55;
    @(negedge clk);
    check("m5_ready", mem_ready, 1);
    check("m5_hazard_hs", hazard, 1);
    next_cyc();
    mem_valid = 0; mem_rd = 0;
    @(negedge clk);
    check("m5_wen", rf_wen, 1);
    check("m5_dsel", rf_dsel, 5);
`ifdef REGFILE_WB_CTRL_BYPASS_EN
    check("m5_hazard_wb", hazard, 0);
    check("m5_fwd1", fwd1_hit, 1);
    check("m5_fwd2", fwd2_hit, 0);
    check("m5_fwd_data", fwd_data, 32'h55);
`else
    check("m5_hazard_wb", hazard, 1);
`endif
    next_cyc();
    @(negedge clk);
    check("m5_hazard_clr", hazard, 0);
    check("m5_no_err", sb_err, 0);
    chk_s1sel = 3;
    #1;
    check("h3_still", hazard, 1);
    next_cyc();
    idle_in();

    // double reserve of x6 -> sticky error
    rsv_valid = 1; rsv_rd = 6;
    next_cyc();
    @(negedge clk);
    check("dbl6_err_pre", sb_err, 0);
    next_cyc();
    rsv_valid = 0;
    @(negedge clk);
    check("dbl6_err", sb_err, 1);
    repeat (3) next_cyc();
    @(negedge clk);
    check("dbl6_err_hold", sb_err, 1);
    next_cyc();
    do_reset();
    chk_s1sel = 6; chk_s2sel = 3;
    @(negedge clk);
    check("rst_err_clr", sb_err, 0);
    check("rst_pend_clr", hazard, 0);
    next_cyc();
    idle_in();

    // load to non-pending x9 -> sticky error
    mem_valid = 1; mem_rd = 9; mem_data = 32'h99;
    @(negedge clk);
    check("m9_ready", mem_ready, 1);
    check("m9_err_pre", sb_err, 0);
    next_cyc();
    idle_in();
    @(negedge clk);
    check("m9_err", sb_err, 1);
    check("m9_wen", rf_wen, 1);
    repeat (2) next_cyc();
    @(negedge clk);
    check("m9_err_hold", sb_err, 1);
    next_cyc();

    // same-cycle set and clear on x8: set wins
    rsv_valid = 1; rsv_rd = 8;
    next_cyc();
    rsv_valid = 0;
    mem_valid = 1; mem_rd = 8; mem_data = 32'h88;
    next_cyc();
    mem_valid = 0;
    rsv_valid = 1; rsv_rd = 8;
    @(negedge clk);
    check("x8_wen", rf_wen, 1);
    next_cyc();
    rsv_valid = 0; chk_s1sel = 8;
    @(negedge clk);
    check("x8_set_wins", hazard, 1);
    next_cyc();
    idle_in();
    do_reset();

    // alu write to x0 handshakes but never writes
    alu_valid = 1; alu_rd = 0; alu_data = 32'h1234;
    @(negedge clk);
    check("x0_ready", alu_ready, 1);
    next_cyc();
    idle_in();
    @(negedge clk);
    check("x0_wen", rf_wen, 0);
    next_cyc();

    // reset during a pending output slot
    rsv_valid = 1; rsv_rd = 4;
    next_cyc();
    rsv_valid = 0;
    alu_valid = 1; alu_rd = 10; alu_data = 32'hA5A5;
    next_cyc();
    alu_valid = 0;
    check("slot_wen_pre", rf_wen, 1);
    rst_n = 0;
    #1;
    check("slot_wen_async", rf_wen, 0);
    check("slot_d_async", rf_d, 0);
    @(negedge clk);
    rst_n = 1;
    chk_s1sel = 4;
    #1;
    check("slot_pend_clr", hazard, 0);
    next_cyc();
    @(negedge clk);
    check("slot_wen_post", rf_wen, 0);
    check("slot_err_post", sb_err, 0);
    idle_in();
    next_cyc();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
